sprite_plot_sink: RTL and testbench
===================================

Name: sprite_plot_sink

Overview:
Receiving end of the sprite pixel stream produced by the per-sprite plot FSMs (user, alien, bullet).
- Accepts sprite-local (x, y, colour) pixels over a valid/ready handshake.
- Offsets each pixel by a latched sprite origin and clips it to the 160x120 screen.
- Buffers pixels in a small FIFO and drives the VGA adapter write port, one pixel per granted cycle.
- Signals completion once all SPR_W*SPR_H pixels have been received and written out.

Parameters:
- SPR_W, 20, sprite width in pixels
- SPR_H, 20, sprite height in pixels
- SCR_W, 160, screen width; screen x >= SCR_W is clipped
- SCR_H, 120, screen height; screen y >= SCR_H is clipped
- FIFO_DEPTH, 4, pixel buffer entries (power of two, >= 2)
- TRANSP_COLOUR, 3'b000, colour treated as transparent (only used with the optional feature)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begin a sprite, latch org_x/org_y
- org_x  in  8  sprite origin x, screen coordinates
- org_y  in  7  sprite origin y, screen coordinates
- pix_valid  in  1  upstream pixel valid
- pix_ready  out  1  sink can accept a pixel
- pix_x  in  5  sprite-local x (0..SPR_W-1)
- pix_y  in  5  sprite-local y (0..SPR_H-1)
- pix_colour  in  3  pixel colour
- grant  in  1  top-level arbiter permits a VGA write this cycle
- vga_x  out  8  VGA adapter x
- vga_y  out  7  VGA adapter y
- vga_colour  out  3  VGA adapter colour
- vga_writeEn  out  1  VGA adapter write strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sprite is fully written

Behaviour:
- Reset (resetn=0 at clk edge) sets:
  - state to IDLE
  - FIFO empty, pixel counter 0
  - vga_writeEn=0, vga_x/vga_y/vga_colour=0
  - pix_ready=0, busy=0, done=0
- Reset applies mid-operation too: in-flight pixels are discarded and no done is produced.
- States:
  - IDLE: pix_ready=0. start=1 latches the origin, clears the counter, next state ACCEPT.
  - ACCEPT: pix_ready = !fifo_full, with no same-cycle pop-through. A pixel is accepted when pix_valid&pix_ready at the edge; each acceptance increments the counter. The acceptance at count SPR_W*SPR_H-1 moves to DRAIN.
  - DRAIN: pix_ready=0. Move to DONE when the FIFO is empty and no write is pending.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored; the origin is never re-latched mid-sprite.
- Address arithmetic, per accepted pixel:
  - sx = {1'b0,org_x} + pix_x, 9 bits; sy = {1'b0,org_y} + pix_y, 8 bits; no wrap.
  - If sx >= SCR_W or sy >= SCR_H, the pixel is counted but not pushed into the FIFO.
- Counter width is $clog2(SPR_W*SPR_H); the counter never wraps within a sprite.
- Output stage (registered):
  - Each cycle with grant=1 and the FIFO non-empty: pop one entry and register vga_x/vga_y/vga_colour with vga_writeEn=1 for one cycle.
  - Otherwise vga_writeEn=0 and vga_x/vga_y/vga_colour hold their values.
- Latency: a pixel accepted at edge E into an empty FIFO, with grant=1, shows vga_writeEn=1 in the cycle after edge E+1.
- grant=0: nothing pops, the FIFO fills, pix_ready drops at FIFO_DEPTH entries. No pixel is lost or duplicated.
- done is asserted in the cycle after the last vga_writeEn of the sprite, or after the last acceptance if every pixel was clipped.

Optional Feature:
- Macro PLOT_TRANSPARENCY_EN.
- Defined: accepted pixels with pix_colour == TRANSP_COLOUR are counted but not pushed (same treatment as clipped pixels).
- Undefined: every in-bounds pixel is written regardless of colour.

Decomposition:
- Package plot_pkg holds:
  - SCR_W/SCR_H defaults and the coordinate widths (8/7)
  - COLOUR_W=3
  - state enum {IDLE, ACCEPT, DRAIN, DONE}
  - pixel entry struct {x[7:0], y[6:0], colour[2:0]}
- One sub-module, plot_pix_fifo: synchronous FIFO of FIFO_DEPTH 18-bit entries with push, pop, full and empty.
- The top level holds the FSM, the adder/clip logic and the output register.

Test Plan:
1. org=(10,20), 400 pixels streamed row-major with valid held high, grant=1 → exactly 400 writes. First write x=10,y=20; last write x=29,y=39. Single done pulse the cycle after the last write; busy low afterwards.
2. org=(150,110), full stream → exactly 100 writes, all with x in 150..159 and y in 110..119. done still pulses once.
3. grant=0 for cycles 5..20 mid-stream → pix_ready=0 after 4 buffered pixels, no writes during that window. After grant returns, 400 unique writes in order.
4. start re-pulsed with org=(0,0) during ACCEPT → ignored; all writes use the original origin.
5. resetn=0 after 37 accepted pixels → next cycle vga_writeEn=0, pix_ready=0, busy=0, no done. A fresh start then writes all 400 pixels.
6. With PLOT_TRANSPARENCY_EN, alternate pixels colour 3'b000/3'b100 → 200 writes, all with colour 3'b100. Without the macro → 400 writes.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared types and constants for the sprite plot sink: screen geometry,
// coordinate/colour widths, the sink FSM state type and the buffered pixel entry.
package plot_pkg;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int COLOUR_W  = 3;
  localparam int ENTRY_W   = X_W + Y_W + COLOUR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } plot_state_e;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pix_entry_t;

endpackage

// File: rtl/plot_pix_fifo.sv
// Small synchronous FIFO holding screen-space pixels between the clip stage
// and the VGA write register. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate occupancy counter.
module plot_pix_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push_s, do_pop_s;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; pushes into a full FIFO and pops from an empty one are dropped.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/sprite_plot_sink.sv
// Sprite plot sink: accepts sprite-local pixels, offsets them by the origin
// latched at start, clips to the screen, buffers them and writes them to the
// VGA adapter one per granted cycle. done pulses once all pixels are out.
// Optional build macro PLOT_TRANSPARENCY_EN: pixels whose colour equals
// TRANSP_COLOUR are counted but never written.
module sprite_plot_sink
  import plot_pkg::*;
#(
  parameter int SPR_W      = 20,
  parameter int SPR_H      = 20,
  parameter int SCR_W      = SCR_W_DEF,
  parameter int SCR_H      = SCR_H_DEF,
  parameter int FIFO_DEPTH = 4
`ifdef PLOT_TRANSPARENCY_EN
  ,
  parameter logic [COLOUR_W-1:0] TRANSP_COLOUR = 3'b000
`endif
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      org_x,
  input  logic [Y_W-1:0]      org_y,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [4:0]          pix_x,
  input  logic [4:0]          pix_y,
  input  logic [COLOUR_W-1:0] pix_colour,
  input  logic                grant,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_writeEn,
  output logic                busy,
  output logic                done
);

  localparam int NPIX  = SPR_W * SPR_H;
  localparam int CNT_W = $clog2(NPIX);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NPIX - 1);

  plot_state_e         state_q, state_d;
  logic [X_W-1:0]      org_x_q, org_x_d;
  logic [Y_W-1:0]      org_y_q, org_y_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                vga_we_q, vga_we_d;
  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [Y_W-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_c_q, vga_c_d;

  logic [X_W:0]        sx_s;
  logic [Y_W:0]        sy_s;
  logic                in_bounds_s, keep_s, accept_s, push_s, pop_s;
  logic                fifo_full_s, fifo_empty_s;
  pix_entry_t          push_entry_s, pop_entry_s;

  // Screen-space address, clip and push decision for the pixel on the input port.
  always_comb begin
    sx_s         = {1'b0, org_x_q} + {4'b0000, pix_x};
    sy_s         = {1'b0, org_y_q} + {3'b000, pix_y};
    in_bounds_s  = (sx_s < (X_W + 1)'(SCR_W)) && (sy_s < (Y_W + 1)'(SCR_H));
`ifdef PLOT_TRANSPARENCY_EN
    keep_s       = in_bounds_s && (pix_colour != TRANSP_COLOUR);
`else
    keep_s       = in_bounds_s;
`endif
    accept_s     = (state_q == ACCEPT) && pix_valid && !fifo_full_s;
    push_s       = accept_s && keep_s;
    pop_s        = grant && !fifo_empty_s;
    push_entry_s = '{x: sx_s[X_W-1:0], y: sy_s[Y_W-1:0], colour: pix_colour};
  end

  plot_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_s),
    .wdata  (push_entry_s),
    .pop    (pop_s),
    .rdata  (pop_entry_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

  // Sprite sequencing: origin latch, pixel counting and drain-to-done.
  always_comb begin
    state_d = state_q;
    org_x_d = org_x_q;
    org_y_d = org_y_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          org_x_d = org_x;
          org_y_d = org_y;
          cnt_d   = '0;
          state_d = ACCEPT;
        end else begin
          state_d = IDLE;
        end
      end
      ACCEPT: begin
        if (accept_s) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DRAIN;
          end else begin
            state_d = ACCEPT;
          end
        end else begin
          state_d = ACCEPT;
        end
      end
      DRAIN: begin
        if (fifo_empty_s) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output stage: a granted pop loads the write register, otherwise it holds.
  always_comb begin
    if (pop_s) begin
      vga_we_d = 1'b1;
      vga_x_d  = pop_entry_s.x;
      vga_y_d  = pop_entry_s.y;
      vga_c_d  = pop_entry_s.colour;
    end else begin
      vga_we_d = 1'b0;
      vga_x_d  = vga_x_q;
      vga_y_d  = vga_y_q;
      vga_c_d  = vga_c_q;
    end
  end

  // State, origin, counter and VGA write registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      org_x_q  <= '0;
      org_y_q  <= '0;
      cnt_q    <= '0;
      vga_we_q <= 1'b0;
      vga_x_q  <= '0;
      vga_y_q  <= '0;
      vga_c_q  <= '0;
    end else begin
      state_q  <= state_d;
      org_x_q  <= org_x_d;
      org_y_q  <= org_y_d;
      cnt_q    <= cnt_d;
      vga_we_q <= vga_we_d;
      vga_x_q  <= vga_x_d;
      vga_y_q  <= vga_y_d;
      vga_c_q  <= vga_c_d;
    end
  end

  assign pix_ready   = (state_q == ACCEPT) && !fifo_full_s;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign vga_writeEn = vga_we_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_c_q;

endmodule

// File: tb/tb_sprite_plot_sink.sv
// Bench for sprite_plot_sink: a transaction-level model (queue of expected
// screen writes plus sprite progress counts) is checked every cycle, and each
// directed scenario ends with hand-computed expectations.
module tb_sprite_plot_sink;

  localparam int NPIX  = 400;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn, start, pix_valid, pix_ready, grant;
  logic [7:0] org_x, vga_x;
  logic [6:0] org_y, vga_y;
  logic [4:0] pix_x, pix_y;
  logic [2:0] pix_colour, vga_colour;
  logic       vga_writeEn, busy, done;

  int checks = 0;
  int errors = 0;

  // per-sprite statistics gathered from the DUT write port
  int n_wr, n_done, first_x, first_y, last_x, last_y, last_c;
  bit in_box, all_c100;

  always #5 clk = ~clk;

  sprite_plot_sink dut (
    .clk(clk), .resetn(resetn), .start(start), .org_x(org_x), .org_y(org_y),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_colour(pix_colour), .grant(grant), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_writeEn(vga_writeEn), .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 60) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model and per-cycle comparison
  initial begin : compare
    logic [17:0] wq[$];
    logic [17:0] ent;
    bit   m_active, m_done, nd, act_pre, keep;
    int   m_acc, m_ox, m_oy, sx, sy, occ;
    bit   ex_we;
    int   ex_x, ex_y, ex_c;
    m_active = 0; m_done = 0; m_acc = 0; m_ox = 0; m_oy = 0;
    ex_we = 0; ex_x = 0; ex_y = 0; ex_c = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("vga_writeEn", vga_writeEn, ex_we);
      chk("vga_x", vga_x, ex_x);
      chk("vga_y", vga_y, ex_y);
      chk("vga_colour", vga_colour, ex_c);
      chk("pix_ready", pix_ready, m_active && (m_acc < NPIX) && (wq.size() < DEPTH));
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      if (vga_writeEn === 1'b1) begin
        if (n_wr == 0) begin first_x = vga_x; first_y = vga_y; end
        last_x = vga_x; last_y = vga_y; last_c = vga_colour;
        if (vga_x < 150 || vga_y < 110) in_box = 0;
        if (vga_colour != 3'b100) all_c100 = 0;
        n_wr++;
      end
      if (done === 1'b1) n_done++;
      // what the next clock edge must produce
      if (!resetn) begin
        wq.delete();
        m_active = 0; m_done = 0; m_acc = 0;
        ex_we = 0; ex_x = 0; ex_y = 0; ex_c = 0;
      end else begin
        occ = wq.size();
        act_pre = m_active;
        nd = m_active && !m_done && (m_acc == NPIX) && (occ == 0);
        if (grant && occ > 0) begin
          ent = wq.pop_front();
          ex_we = 1; ex_x = int'(ent[17:10]); ex_y = int'(ent[9:3]); ex_c = int'(ent[2:0]);
        end else begin
          ex_we = 0;
        end
        if (m_active && m_acc < NPIX && pix_valid && occ < DEPTH) begin
          sx = m_ox + int'(pix_x);
          sy = m_oy + int'(pix_y);
          keep = (sx < 160) && (sy < 120);
`ifdef PLOT_TRANSPARENCY_EN
          if (pix_colour == 3'b000) keep = 0;
`endif
          if (keep) wq.push_back({8'(sx), 7'(sy), pix_colour});
          m_acc++;
        end
        if (m_done) m_active = 0;
        m_done = nd;
        if (!act_pre && start) begin
          m_active = 1; m_acc = 0; m_ox = int'(org_x); m_oy = int'(org_y);
          n_wr = 0; n_done = 0; in_box = 1; all_c100 = 1;
        end
      end
    end
  end

  // Stream one sprite row-major; optional grant gap, start re-pulse or mid-run reset.
  task automatic run_sprite(input int ox, input int oy, input int glo, input int ghi,
                            input int restart_at, input int reset_at, input bit alt);
    int idx, cyc;
    bit acc, fin;
    @(posedge clk); #1;
    start = 1; org_x = 8'(ox); org_y = 7'(oy); pix_valid = 0; grant = 1;
    @(posedge clk); #1;
    start = 0;
    idx = 0; cyc = 0; fin = 0;
    while (!fin) begin
      pix_valid  = (idx < NPIX);
      pix_x      = 5'(idx % 20);
      pix_y      = 5'(idx / 20);
      pix_colour = alt ? ((idx % 2) ? 3'b100 : 3'b000) : 3'((idx % 7) + 1);
      grant      = !(cyc >= glo && cyc <= ghi);
      start      = (cyc == restart_at);
      if (start) begin org_x = 8'd0; org_y = 7'd0; end
      @(negedge clk);
      acc = pix_valid && pix_ready;
      if (done === 1'b1) fin = 1;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
      if (!fin && reset_at > 0 && idx == reset_at) begin
        resetn = 0; pix_valid = 0; start = 0;
        @(posedge clk); #1;
        resetn = 1;
        chk("rst_writeEn", vga_writeEn, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        fin = 1;
      end
      if (!fin && cyc > 3000) begin
        chk("done_timeout", done, 1);
        fin = 1;
      end
    end
    start = 0; pix_valid = 0; grant = 1;
  endtask

  initial begin
    resetn = 0; start = 0; org_x = 0; org_y = 0; pix_valid = 0;
    pix_x = 0; pix_y = 0; pix_colour = 0; grant = 1;
    n_wr = 0; n_done = 0; first_x = 0; first_y = 0; last_x = 0; last_y = 0; last_c = 0;
    in_box = 1; all_c100 = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_writeEn", vga_writeEn, 0);
    chk("reset_vga_x", vga_x, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", pix_ready, 0);
    chk("reset_done", done, 0);
    resetn = 1;

    // 1: basic full sprite
    run_sprite(10, 20, -1, -1, -1, 0, 0);
    chk("t1_writes", n_wr, 400);
    chk("t1_first_x", first_x, 10);
    chk("t1_first_y", first_y, 20);
    chk("t1_last_x", last_x, 29);
    chk("t1_last_y", last_y, 39);
    chk("t1_last_c", last_c, 1);
    chk("t1_dones", n_done, 1);
    chk("t1_busy_after", busy, 0);

    // 2: bottom-right corner clipping
    run_sprite(150, 110, -1, -1, -1, 0, 0);
    chk("t2_writes", n_wr, 100);
    chk("t2_in_box", in_box, 1);
    chk("t2_last_x", last_x, 159);
    chk("t2_last_y", last_y, 119);
    chk("t2_dones", n_done, 1);

    // 3: grant withheld for a window mid-stream
    run_sprite(30, 40, 5, 20, -1, 0, 0);
    chk("t3_writes", n_wr, 400);
    chk("t3_first_x", first_x, 30);
    chk("t3_last_y", last_y, 59);
    chk("t3_dones", n_done, 1);

    // 4: start re-pulsed with origin (0,0) while accepting
    run_sprite(40, 50, -1, -1, 30, 0, 0);
    chk("t4_writes", n_wr, 400);
    chk("t4_first_x", first_x, 40);
    chk("t4_first_y", first_y, 50);
    chk("t4_last_x", last_x, 59);
    chk("t4_last_y", last_y, 69);

    // 5: reset after 37 accepted pixels, then a fresh sprite
    run_sprite(5, 5, -1, -1, -1, 37, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_done", n_done, 0);
    chk("t5_idle_busy", busy, 0);
    run_sprite(5, 5, -1, -1, -1, 0, 0);
    chk("t5_writes", n_wr, 400);
    chk("t5_last_x", last_x, 24);
    chk("t5_dones", n_done, 1);

    // 6: alternating colours 000/100
    run_sprite(60, 70, -1, -1, -1, 0, 1);
`ifdef PLOT_TRANSPARENCY_EN
    chk("t6_writes", n_wr, 200);
    chk("t6_all_c100", all_c100, 1);
`else
    chk("t6_writes", n_wr, 400);
`endif
    chk("t6_last_c", last_c, 3'b100);
    chk("t6_dones", n_done, 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
